// File: rtl/gate_lab_seq.sv
// gate_lab_seq: clocked, parametrised switch/LED gate lab block.
// Board switches and the mode button are synchronised and debounced per bit.
// The button steps a 3-bit function code. A registered result applies that
// bitwise function to CHANNELS independent A/B operand pairs.
module gate_lab_seq #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 1,
  parameter int DEBOUNCE = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] a_in,
  input  logic [CHANNELS*WIDTH-1:0] b_in,
  input  logic                      mode_btn,
  output logic [CHANNELS*WIDTH-1:0] result,
  output logic [2:0]                mode,
  output logic                      upd
);

  localparam int N  = CHANNELS * WIDTH;
  localparam int NB = 2 * N + 1;              // every A bit, every B bit, button
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [2:0] {
    FN_AND    = 3'd0,
    FN_OR     = 3'd1,
    FN_NOT_A  = 3'd2,
    FN_XOR    = 3'd3,
    FN_NAND   = 3'd4,
    FN_NOR    = 3'd5,
    FN_XNOR   = 3'd6,
    FN_PASS_B = 3'd7
  } fn_e;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] stable;
  logic [CW-1:0] cnt [NB];

  logic [N-1:0]  a_stb;
  logic [N-1:0]  b_stb;
  logic          btn_stb;
  logic          btn_dly;
  logic [2:0]    mode_q;
  logic [N-1:0]  next_result;

  // All asynchronous inputs share one synchroniser/debounce bank.
  assign raw = {mode_btn, b_in, a_in};

  // Two-flop synchroniser for every input bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, giving
      // two real flop stages; blocking here would collapse them into one.
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: the stable value only follows the synchronised value
  // after it has disagreed for DEBOUNCE consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      // NOTE: the counter array is a bank of ordinary flops, not a RAM, so it
      // is reset like any other state; pending counts must not survive reset.
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE - 1)) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign a_stb   = stable[N-1:0];
  assign b_stb   = stable[2*N-1:N];
  assign btn_stb = stable[2*N];

  // Mode steps on each debounced rising edge of the button, wrapping 7 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_dly <= 1'b0;
      mode_q  <= 3'd0;
    end else begin
      btn_dly <= btn_stb;
      if (btn_stb && !btn_dly) mode_q <= mode_q + 3'd1;
    end
  end

  assign mode = mode_q;

  // Bitwise function of the stable operands; channels never mix because every
  // operation is purely per bit.
  always_comb begin
    // NOTE: default first so every path assigns next_result and no latch is
    // inferred even if the case list is later edited.
    next_result = '0;
    case (fn_e'(mode_q))
      FN_AND:    next_result = a_stb & b_stb;
      FN_OR:     next_result = a_stb | b_stb;
      FN_NOT_A:  next_result = ~a_stb;
      FN_XOR:    next_result = a_stb ^ b_stb;
      FN_NAND:   next_result = ~(a_stb & b_stb);
      FN_NOR:    next_result = ~(a_stb | b_stb);
      FN_XNOR:   next_result = ~(a_stb ^ b_stb);
      FN_PASS_B: next_result = b_stb;
      default:   next_result = '0;
    endcase
  end

  // Output register; upd flags exactly the cycles in which result changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      upd    <= 1'b0;
    end else begin
      result <= next_result;
      upd    <= (next_result != result);
    end
  end

endmodule
